// File: rtl/cla5_word_sequencer.sv
// rtl/cla5_word_sequencer.sv - multi-cycle wide adder that time-shares one 5-bit CLA slice
// Digits are fed LSB-first; the slice carry is registered between cycles.
module cla5_word_sequencer #(
    parameter int SLICES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [5*SLICES-1:0]   a,
    input  logic [5*SLICES-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [5*SLICES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic [4:0]            slice_a,
    output logic [4:0]            slice_b,
    output logic                  slice_cin,
    input  logic [4:0]            slice_sum,
    input  logic                  slice_cout
);

    localparam int W  = 5 * SLICES;
    localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SLICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [4:0]      dig_a, dig_b;
    logic            in_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Digit mux written as a compare loop so idx never indexes past the operand
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int k = 0; k < SLICES; k++) begin
            if (idx_q == IW'(k)) begin
                dig_a = a_q[5*k +: 5];
                dig_b = b_q[5*k +: 5];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int k = 0; k < SLICES; k++) begin
                    if (idx_q == IW'(k)) begin
                        sum_d[5*k +: 5] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[4] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_run    = (state_q == ST_RUN);
    assign busy      = in_run;
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign slice_a   = in_run ? dig_a : 5'd0;
    assign slice_b   = in_run ? dig_b : 5'd0;
    assign slice_cin = in_run & carry_q;

endmodule
